// File: rtl/triadic_alu_issue_arbiter.sv
// triadic_alu_issue_arbiter: arbitrates requesters onto a pipelined ALU and retires results into private R registers.
// Define TRIADIC_ALU_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest eligible index wins.
module triadic_alu_issue_arbiter #(
    parameter int WORD_WIDTH  = 36,
    parameter int CTRL_WIDTH  = 20,
    parameter int REQ_COUNT   = 4,
    parameter int ALU_LATENCY = 4,
    localparam int RID_WIDTH  = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
    input  logic                             clock,
    input  logic                             clear,
    input  logic [REQ_COUNT-1:0]             req_valid,
    output logic [REQ_COUNT-1:0]             req_ready,
    input  logic [REQ_COUNT*CTRL_WIDTH-1:0]  req_control,
    input  logic [REQ_COUNT*WORD_WIDTH-1:0]  req_A,
    input  logic [REQ_COUNT*WORD_WIDTH-1:0]  req_B,
    input  logic [REQ_COUNT*WORD_WIDTH-1:0]  req_S,
    output logic [CTRL_WIDTH-1:0]            alu_control,
    output logic [WORD_WIDTH-1:0]            alu_A,
    output logic [WORD_WIDTH-1:0]            alu_B,
    output logic [WORD_WIDTH-1:0]            alu_R,
    output logic [WORD_WIDTH-1:0]            alu_S,
    output logic                             alu_R_zero,
    output logic                             alu_R_negative,
    input  logic [WORD_WIDTH-1:0]            alu_Ra,
    input  logic [WORD_WIDTH-1:0]            alu_Rb,
    output logic                             result_valid,
    output logic [RID_WIDTH-1:0]             result_id,
    output logic [WORD_WIDTH-1:0]            result_Ra,
    output logic [WORD_WIDTH-1:0]            result_Rb
);
    logic [REQ_COUNT-1:0]  busy;
    logic [REQ_COUNT-1:0]  eligible;
    logic [WORD_WIDTH-1:0] r_q [REQ_COUNT];
    logic [ALU_LATENCY:0]  tag_v;
    logic [RID_WIDTH-1:0]  tag_id [ALU_LATENCY+1];
    logic                  hs;
    logic [RID_WIDTH-1:0]  gnt;

    assign eligible = req_valid & ~busy;

`ifdef TRIADIC_ALU_ARBITER_ROUND_ROBIN_EN
    logic [RID_WIDTH-1:0] ptr;

    // Descending scan so the candidate closest to ptr is written last and wins.
    always_comb begin
        hs  = 1'b0;
        gnt = '0;
        for (int k = REQ_COUNT - 1; k >= 0; k--) begin
            if (eligible[(int'(ptr) + k) % REQ_COUNT]) begin
                hs  = 1'b1;
                gnt = RID_WIDTH'((int'(ptr) + k) % REQ_COUNT);
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            ptr <= '0;
        else if (hs)
            ptr <= (int'(gnt) == REQ_COUNT - 1) ? '0 : gnt + RID_WIDTH'(1);
    end
`else
    always_comb begin
        hs  = 1'b0;
        gnt = '0;
        for (int k = REQ_COUNT - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                hs  = 1'b1;
                gnt = RID_WIDTH'(k);
            end
        end
    end
`endif

    assign req_ready      = (hs && !clear) ? (REQ_COUNT'(1) << gnt) : '0;
    assign alu_R_zero     = ~|alu_R;
    assign alu_R_negative = alu_R[WORD_WIDTH-1];
    assign result_valid   = tag_v[ALU_LATENCY];
    assign result_id      = tag_id[ALU_LATENCY];
    assign result_Ra      = alu_Ra;
    assign result_Rb      = alu_Rb;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            busy        <= '0;
            tag_v       <= '0;
            alu_control <= '0;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_R       <= '0;
            alu_S       <= '0;
            for (int k = 0; k <= ALU_LATENCY; k++) tag_id[k] <= '0;
            for (int i = 0; i < REQ_COUNT; i++) r_q[i] <= '0;
        end else begin
            alu_control <= hs ? req_control[gnt*CTRL_WIDTH +: CTRL_WIDTH] : '0;
            alu_A       <= hs ? req_A[gnt*WORD_WIDTH +: WORD_WIDTH] : '0;
            alu_B       <= hs ? req_B[gnt*WORD_WIDTH +: WORD_WIDTH] : '0;
            alu_S       <= hs ? req_S[gnt*WORD_WIDTH +: WORD_WIDTH] : '0;
            alu_R       <= hs ? r_q[gnt] : '0;
            tag_v       <= {tag_v[ALU_LATENCY-1:0], hs};
            tag_id[0]   <= gnt;
            for (int k = 1; k <= ALU_LATENCY; k++) tag_id[k] <= tag_id[k-1];
            // A retiring requester is still busy, so it can never be the one granted this cycle.
            for (int i = 0; i < REQ_COUNT; i++) begin
                if (hs && gnt == RID_WIDTH'(i))
                    busy[i] <= 1'b1;
                else if (result_valid && result_id == RID_WIDTH'(i))
                    busy[i] <= 1'b0;
            end
            if (result_valid)
                r_q[result_id] <= alu_Ra;
        end
    end
endmodule

// File: tb/tb_triadic_alu_issue_arbiter.sv
// tb_triadic_alu_issue_arbiter: directed and randomized checks against a queue-based reference model.
module tb_triadic_alu_issue_arbiter;
    localparam int W  = 36;
    localparam int CW = 20;
    localparam int N  = 4;
    localparam int L  = 4;
    localparam int RW = 2;

    logic            clock = 1'b0;
    logic            clear = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*CW-1:0] req_control = '0;
    logic [N*W-1:0]  req_A = '0, req_B = '0, req_S = '0;
    logic [CW-1:0]   alu_control;
    logic [W-1:0]    alu_A, alu_B, alu_R, alu_S;
    logic            alu_R_zero, alu_R_negative;
    logic [W-1:0]    alu_Ra = '0, alu_Rb = '0;
    logic            result_valid;
    logic [RW-1:0]   result_id;
    logic [W-1:0]    result_Ra, result_Rb;

    triadic_alu_issue_arbiter dut (
        .clock(clock), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_control(req_control), .req_A(req_A), .req_B(req_B), .req_S(req_S),
        .alu_control(alu_control), .alu_A(alu_A), .alu_B(alu_B), .alu_R(alu_R), .alu_S(alu_S),
        .alu_R_zero(alu_R_zero), .alu_R_negative(alu_R_negative),
        .alu_Ra(alu_Ra), .alu_Rb(alu_Rb),
        .result_valid(result_valid), .result_id(result_id),
        .result_Ra(result_Ra), .result_Rb(result_Rb)
    );

    always #5 clock = ~clock;

    typedef struct {int id; int due;} op_t;
    op_t           q[$];
    logic [W-1:0]  r_m [N];
    int            ptr_m = 0, cyc = 0, last_grant = -1;
    int            checks = 0, errors = 0;
    logic [CW-1:0] p_ctrl = '0;
    logic [W-1:0]  p_A = '0, p_B = '0, p_S = '0, p_R = '0;
    logic [N-1:0]  last_ready;
    logic          last_rv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_flight(input int id);
        foreach (q[j]) if (q[j].id == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int pick_grant();
        for (int k = 0; k < N; k++) begin
            int idx = (ptr_m + k) % N;
            if (req_valid[idx] && !in_flight(idx)) return idx;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [63:0] v = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: return '0;
            1: return {1'b1, v[W-2:0]};
            default: return v[W-1:0];
        endcase
    endfunction

    task automatic set_ops(input int i, input logic [CW-1:0] c, input logic [W-1:0] a, b, s);
        req_control[i*CW +: CW] = c;
        req_A[i*W +: W] = a;
        req_B[i*W +: W] = b;
        req_S[i*W +: W] = s;
    endtask

    task automatic rand_ops(input int i);
        set_ops(i, CW'($urandom), rand_word(), rand_word(), rand_word());
    endtask

    // One clock cycle: predict, sample at the falling edge, then advance the model at the rising edge.
    task automatic step();
        int g, rj;
        g  = clear ? -1 : pick_grant();
        rj = -1;
        foreach (q[j]) if (q[j].due == cyc) rj = j;
        @(negedge clock);
        last_ready = req_ready;
        last_rv    = result_valid;
        if (clear) begin
            chk("clr_ready", req_ready, 0);
            chk("clr_rvalid", result_valid, 0);
            chk("clr_rid", result_id, 0);
        end else begin
            chk("req_ready", req_ready, g >= 0 ? (64'd1 << g) : 64'd0);
            chk("alu_control", alu_control, p_ctrl);
            chk("alu_A", alu_A, p_A);
            chk("alu_B", alu_B, p_B);
            chk("alu_S", alu_S, p_S);
            chk("alu_R", alu_R, p_R);
            chk("alu_R_zero", alu_R_zero, p_R == '0);
            chk("alu_R_negative", alu_R_negative, p_R[W-1]);
            chk("result_valid", result_valid, rj >= 0);
            if (rj >= 0) begin
                chk("result_id", result_id, q[rj].id);
                chk("result_Ra", result_Ra, alu_Ra);
                chk("result_Rb", result_Rb, alu_Rb);
            end
        end
        @(posedge clock);
        if (clear) begin
            q.delete();
            foreach (r_m[i]) r_m[i] = '0;
            ptr_m = 0;
            {p_ctrl, p_A, p_B, p_S, p_R} = '0;
            last_grant = -1;
        end else begin
            if (rj >= 0) begin
                r_m[q[rj].id] = alu_Ra;
                q.delete(rj);
            end
            if (g >= 0) begin
                q.push_back('{g, cyc + L + 1});
                p_ctrl = req_control[g*CW +: CW];
                p_A = req_A[g*W +: W];
                p_B = req_B[g*W +: W];
                p_S = req_S[g*W +: W];
                p_R = r_m[g];
`ifdef TRIADIC_ALU_ARBITER_ROUND_ROBIN_EN
                ptr_m = (g + 1) % N;
`endif
            end else begin
                {p_ctrl, p_A, p_B, p_S, p_R} = '0;
            end
            last_grant = g;
        end
        cyc++;
        #1;
    endtask

    task automatic reset_dut();
        req_valid = '0;
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0;
        repeat (L + 3) step();
    endtask

    logic [N-1:0] exp_grants [8];

    initial begin
        foreach (r_m[i]) r_m[i] = '0;
        reset_dut();

        // Single requester 2 issue and its retire ALU_LATENCY+1 cycles later.
        set_ops(2, 20'h00abc, 36'd5, 36'd3, 36'd7);
        req_valid = 4'b0100;
        step();
        chk("t30_ready", last_ready, 4'b0100);
        req_valid = '0;
        chk("t30_alu_A", alu_A, 5);
        chk("t30_alu_B", alu_B, 3);
        chk("t30_alu_S", alu_S, 7);
        chk("t30_alu_R", alu_R, 0);
        chk("t30_alu_R_zero", alu_R_zero, 1);
        repeat (4) step();
        chk("t30_rvalid", result_valid, 1);
        chk("t30_rid", result_id, 2);
        drain();

        // All/two requesters held valid: arbitration order and re-grant timing.
        reset_dut();
        for (int i = 0; i < N; i++) rand_ops(i);
`ifdef TRIADIC_ALU_ARBITER_ROUND_ROBIN_EN
        req_valid = 4'b1111;
        exp_grants = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
`else
        req_valid = 4'b1010;
        exp_grants = '{4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b1000};
`endif
        for (int c = 0; c < 8; c++) begin
            alu_Ra = rand_word();
            step();
            chk($sformatf("t31_grant_c%0d", c), last_ready, exp_grants[c]);
        end
        drain();

        // Negative 36-bit result written back into req 1's R, req 0 sees its own R.
        reset_dut();
        rand_ops(0);
        rand_ops(1);
        req_valid = 4'b0011;
        for (int c = 0; c < 10; c++) begin
            alu_Ra = (c == 5) ? 36'h0_0000_0123 : (c == 6) ? 36'h8_0000_0000 : rand_word();
            alu_Rb = rand_word();
            step();
            if (c == 6) begin
                chk("t33_grant0", last_ready, 4'b0001);
                chk("t33_r0", alu_R, 36'h0_0000_0123);
                chk("t33_r0_neg", alu_R_negative, 0);
            end
            if (c == 7) begin
                chk("t33_grant1", last_ready, 4'b0010);
                chk("t33_r1", alu_R, 36'h8_0000_0000);
                chk("t33_r1_neg", alu_R_negative, 1);
                chk("t33_r1_zero", alu_R_zero, 0);
            end
        end
        drain();

        // Clear with two operations in flight.
        reset_dut();
        alu_Ra = 36'h5_5555_5555;
        req_valid = 4'b0011;
        step();
        step();
        req_valid = '0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        req_valid = 4'b0011;
        step();
        chk("t34_grant0", last_ready, 4'b0001);
        chk("t34_r0", alu_R, 0);
        step();
        chk("t34_grant1", last_ready, 4'b0010);
        chk("t34_no_ret5", last_rv, 0);
        chk("t34_r1", alu_R, 0);
        req_valid = '0;
        step();
        chk("t34_no_ret6", last_rv, 0);
        drain();

        // Randomized traffic with occasional clears.
        for (int i = 0; i < N; i++) rand_ops(i);
        for (int c = 0; c < 3000; c++) begin
            alu_Ra = rand_word();
            alu_Rb = rand_word();
            clear = ($urandom_range(0, 199) == 0);
            step();
            clear = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || i == last_grant) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    rand_ops(i);
                end
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
